// File: rtl/mem_pkg.sv
// Shared definitions for the frame reader on the read side of an async FIFO.
//   DATA_WIDTH    : width of one FIFO word (payload plus end-of-frame flag)
//   EOF_BIT       : bit of a FIFO word that marks the last word of a frame
//   PAYLOAD_WIDTH : width of the payload delivered downstream
//   reader_state_e: read-side frame state machine encoding
package mem_pkg;

  localparam int DATA_WIDTH    = 9;
  localparam int EOF_BIT       = DATA_WIDTH - 1;
  localparam int PAYLOAD_WIDTH = DATA_WIDTH - 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FRAME = 2'd1,
    ST_DROP  = 2'd2
  } reader_state_e;

endpackage

// File: rtl/frame_out_buf.sv
// Two-entry output buffer with a registered head.
//   clk_i, rst_i   : clock and synchronous active-high reset
//   push_i         : write push_data_i at the tail this cycle
//   push_data_i    : word to store
//   pop_i          : remove the head word this cycle
//   count_o        : number of stored words (0..2)
//   full_o/empty_o : occupancy flags
//   head_o         : oldest stored word (zero after reset)
module frame_out_buf
  import mem_pkg::*;
#(
  parameter int W = DATA_WIDTH
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [1:0]   count_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);

  logic [W-1:0] entry0_q, entry0_d;
  logic [W-1:0] entry1_q, entry1_d;
  logic [1:0]   count_q, count_d;
  logic         pop_eff;
  logic         push_eff;
  logic [1:0]   cnt_after_pop;

  // Entry 0 is always the head; a pop shifts entry 1 forward, and a push
  // lands in whichever slot is the tail once the pop has been applied, so a
  // simultaneous push and pop leaves the count unchanged.
  always_comb begin
    pop_eff       = pop_i && (count_q != 2'd0);
    cnt_after_pop = count_q - {1'b0, pop_eff};
    push_eff      = push_i && (cnt_after_pop != 2'd2);
    entry0_d      = entry0_q;
    entry1_d      = entry1_q;
    if (pop_eff) begin
      entry0_d = entry1_q;
    end
    if (push_eff) begin
      if (cnt_after_pop == 2'd0) begin
        entry0_d = push_data_i;
      end else begin
        entry1_d = push_data_i;
      end
    end
    count_d = cnt_after_pop + {1'b0, push_eff};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      entry0_q <= '0;
      entry1_q <= '0;
      count_q  <= 2'd0;
    end else begin
      entry0_q <= entry0_d;
      entry1_q <= entry1_d;
      count_q  <= count_d;
    end
  end

  assign count_o = count_q;
  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  assign head_o  = entry0_q;

endmodule

// File: rtl/fifo_frame_reader.sv
// Reads framed words out of an async FIFO read port and streams them
// downstream, with the option to discard one whole frame on request.
//   rclk, rrst           : clock and synchronous active-high reset
//   fifo_r_en            : read strobe to the FIFO (never high while empty)
//   fifo_r_data          : FIFO word, valid the cycle after an accepted read
//   fifo_r_empty         : FIFO empty flag
//   m_valid/m_ready      : downstream handshake
//   m_data/m_last        : payload and end-of-frame flag of the head word
//   drop_req/drop_ack    : discard-next-frame request and its one-cycle ack
//   frames_out           : frames delivered (wraps)
//   frames_dropped       : frames fully discarded (wraps)
//   dbg_state_o          : current read-side state, for observation
//
// Handshake: a word transfers on every rising edge where m_valid and m_ready
// are both high; once m_valid is raised, m_data/m_last hold steady and
// m_valid stays high until that transfer happens.
module fifo_frame_reader
  import mem_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                     rclk,
  input  logic                     rrst,
  output logic                     fifo_r_en,
  input  logic [DATA_WIDTH-1:0]    fifo_r_data,
  input  logic                     fifo_r_empty,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [PAYLOAD_WIDTH-1:0] m_data,
  output logic                     m_last,
  input  logic                     drop_req,
  output logic                     drop_ack,
  output logic [CNT_WIDTH-1:0]     frames_out,
  output logic [CNT_WIDTH-1:0]     frames_dropped,
  output reader_state_e            dbg_state_o
);

  reader_state_e          state_q, state_d;
  logic                   rd_pending_q;
  logic                   drop_ack_q, drop_ack_d;
  logic [CNT_WIDTH-1:0]   frames_out_q;
  logic [CNT_WIDTH-1:0]   frames_dropped_q;

  logic                   arrival;
  logic                   arr_eof;
  logic                   pop;
  logic                   push_raw;
  logic                   buf_push;
  logic                   dropped_inc;
  logic                   rd_want;
  logic                   room;
  logic [2:0]             occ;
  logic [1:0]             buf_count;
  logic                   buf_full;
  logic                   buf_empty;
  logic [DATA_WIDTH-1:0]  buf_head;

  assign arrival = rd_pending_q;
  assign arr_eof = fifo_r_data[EOF_BIT];
  assign m_valid = !buf_empty;
  assign pop     = m_valid && m_ready;

  // Occupancy the buffer will have once the word now in flight has landed
  // and this cycle's pop has happened; a new read is only safe below 2.
  assign occ  = {1'b0, buf_count} + {2'b00, rd_pending_q} - {2'b00, pop};
  assign room = (occ < 3'd2);

  always_comb begin
    state_d     = state_q;
    drop_ack_d  = 1'b0;
    push_raw    = 1'b0;
    dropped_inc = 1'b0;
    rd_want     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        rd_want = room;
        if (arrival) begin
          push_raw = 1'b1;
          if (!arr_eof) begin
            state_d = ST_FRAME;
          end
        end
        // A word arriving in this same cycle is handled as IDLE traffic
        // first. If it opens a multi-word frame the drop would cut that
        // frame in half, so the request is left unacknowledged.
        if (drop_req && !(arrival && !arr_eof)) begin
          state_d    = ST_DROP;
          drop_ack_d = 1'b1;
        end
      end
      ST_FRAME: begin
        rd_want = room;
        if (arrival) begin
          push_raw = 1'b1;
          if (arr_eof) begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DROP: begin
        // Discarded words need no buffer space, except the read issued in
        // the cycle the dropped frame's last word arrives: that one belongs
        // to the next frame and lands in IDLE.
        rd_want = !(arrival && arr_eof) || room;
        if (arrival && arr_eof) begin
          state_d     = ST_IDLE;
          dropped_inc = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign fifo_r_en = rd_want && !fifo_r_empty && !rrst;
  assign buf_push  = push_raw && (!buf_full || pop);

  always_ff @(posedge rclk) begin
    if (rrst) begin
      state_q          <= ST_IDLE;
      rd_pending_q     <= 1'b0;
      drop_ack_q       <= 1'b0;
      frames_out_q     <= '0;
      frames_dropped_q <= '0;
    end else begin
      state_q          <= state_d;
      rd_pending_q     <= fifo_r_en;
      drop_ack_q       <= drop_ack_d;
      frames_out_q     <= frames_out_q
                          + {{(CNT_WIDTH-1){1'b0}}, (pop && buf_head[EOF_BIT])};
      frames_dropped_q <= frames_dropped_q + {{(CNT_WIDTH-1){1'b0}}, dropped_inc};
    end
  end

  frame_out_buf #(
    .W (DATA_WIDTH)
  ) u_buf (
    .clk_i       (rclk),
    .rst_i       (rrst),
    .push_i      (buf_push),
    .push_data_i (fifo_r_data),
    .pop_i       (pop),
    .count_o     (buf_count),
    .full_o      (buf_full),
    .empty_o     (buf_empty),
    .head_o      (buf_head)
  );

  assign m_data         = buf_head[PAYLOAD_WIDTH-1:0];
  assign m_last         = buf_head[EOF_BIT];
  assign drop_ack       = drop_ack_q;
  assign frames_out     = frames_out_q;
  assign frames_dropped = frames_dropped_q;
  assign dbg_state_o    = state_q;

endmodule

// File: doc/fifo_frame_reader.md
FIFO_FRAME_READER -- requirements
Module: fifo_frame_reader

Interface
REQ-001 Parameters SHALL be: CNT_WIDTH, 16, width of the frame statistics counters.
REQ-002 The block SHALL have one clock and one reset; reset SHALL be synchronous and active-high.
REQ-003 rclk  input  1  single clock; all logic on its rising edge.
REQ-004 rrst  input  1  synchronous active-high reset.
REQ-005 fifo_r_en  output  1  read strobe to the async FIFO read port.
REQ-006 fifo_r_data  input  DATA_WIDTH  FIFO word, registered; valid the cycle after an accepted read; bit EOF_BIT marks the last word of a frame.
REQ-007 fifo_r_empty  input  1  FIFO empty flag.
REQ-008 m_valid  output  1  output word valid.
REQ-009 m_ready  input  1  downstream accepts the word when m_valid is high.
REQ-010 m_data  output  PAYLOAD_WIDTH  payload, fifo_r_data[PAYLOAD_WIDTH-1:0].
REQ-011 m_last  output  1  copy of the word's EOF_BIT.
REQ-012 drop_req  input  1  single-cycle request to discard the next whole frame.
REQ-013 drop_ack  output  1  one-cycle pulse when drop_req is accepted.
REQ-014 frames_out  output  CNT_WIDTH  count of m_valid&m_ready&m_last handshakes.
REQ-015 frames_dropped  output  CNT_WIDTH  count of fully discarded frames.

Function
REQ-016 A read SHALL be accepted when fifo_r_en=1 and fifo_r_empty=0; fifo_r_en SHALL never be high while fifo_r_empty=1.
REQ-017 Arrival: the cycle after an accepted read, fifo_r_data SHALL be consumed exactly once (rd_pending flag).
REQ-018 The output buffer SHALL hold 2 entries; in IDLE/FRAME, fifo_r_en = !fifo_r_empty && (buf_count + rd_pending - pop) < 2, where pop = m_valid&m_ready.
REQ-019 An arriving word in IDLE/FRAME SHALL be written to the buffer tail; m_valid SHALL rise the cycle after arrival (read-to-valid latency 2 cycles).
REQ-020 With fifo_r_empty=0 and m_ready=1 continuously, throughput SHALL be 1 word per cycle.
REQ-021 m_data/m_last SHALL be stable while m_valid=1 and m_ready=0; no word SHALL be lost, duplicated or reordered.
REQ-022 The read-side state machine SHALL have states IDLE, FRAME, DROP; transitions occur on arrival or drop_req only.
REQ-023 IDLE: arrival with EOF=0 -> FRAME; arrival with EOF=1 -> IDLE (single-word frame).
REQ-024 FRAME: arrival with EOF=1 -> IDLE; drop_req ignored (no drop_ack).
REQ-025 IDLE: drop_req=1 -> DROP with drop_ack=1 the next cycle; an in-flight read arriving later is discarded as part of the dropped frame; a same-cycle arrival is processed in IDLE before the transition.
REQ-026 DROP: fifo_r_en = !fifo_r_empty regardless of buffer occupancy; arriving words SHALL NOT enter the buffer; arrival with EOF=1 -> IDLE and frames_dropped increments.
REQ-027 DROP SHALL NOT affect words already in the buffer; they drain normally.
REQ-028 drop_req in DROP SHALL be ignored.
REQ-029 Counters SHALL wrap modulo 2^CNT_WIDTH without saturation.
REQ-030 Simultaneous push and pop SHALL leave buf_count unchanged.

Reset
REQ-031 On rrst: state=IDLE, buf_count=0, rd_pending=0, fifo_r_en=0, m_valid=0, m_data=0, m_last=0, drop_ack=0, frames_out=0, frames_dropped=0.
REQ-032 Reset mid-frame or with a read in flight SHALL discard the in-flight word and buffer contents; the first arrival after reset is treated as a frame start.

Structure
REQ-033 mem_pkg SHALL hold DATA_WIDTH, EOF_BIT (=DATA_WIDTH-1), PAYLOAD_WIDTH (=DATA_WIDTH-1) and the reader state enum.
REQ-034 The 2-entry buffer SHALL be a sub-module frame_out_buf (push/pop, count, full/empty, registered head).

Verification (DATA_WIDTH=9)
REQ-035 FIFO holds 0x041,0x042,0x143, m_ready=1 -> m_data 0x41,0x42,0x43 on consecutive cycles, m_last only on 0x43, first m_valid 2 cycles after first fifo_r_en, frames_out=1.
REQ-036 m_ready=0 for 10 cycles with 5 words queued -> exactly 2 reads issued, m_data held at first word; release -> all 5 in order, no gaps.
REQ-037 IDLE, drop_req with frames [0x001,0x102][0x1AA] queued -> drop_ack once, 0x01/0x02 never appear, next output 0xAA with m_last, frames_dropped=1.
REQ-038 drop_req during FRAME -> no drop_ack, frame delivered intact, frames_dropped unchanged.
REQ-039 rrst for 1 cycle with a read in flight and 2 words buffered -> all outputs at reset values next cycle; following word arrives as frame start.
REQ-040 Preload frames_out=0xFFFF (2^16-1 frames) then 1 more frame -> frames_out=0x0000.
